mc_controller: RTL
==================

# mc_controller

Multicycle MIPS control unit: a Moore state machine that sequences the shared datapath registers (PC, instruction register, data/A/B/ALUOut registers) and the single memory port across several cycles per instruction. It decodes the opcode held in the instruction register, steps each instruction through fetch, decode, execute, memory and writeback states, and drives every enable and mux select in the multicycle datapath. All architectural write enables are gated so the datapath changes state only under this controller.

## Interface
Parameters: none.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk
- op  input  6  instruction[31:26] from the instruction register
- funct  input  6  instruction[5:0] from the instruction register
- zero  input  1  ALU zero flag
- pcen  output  1  PC register enable
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  output  1  memory write strobe
- irwrite  output  1  instruction register enable
- regdst  output  1  write register select: 0 = rt, 1 = rd
- memtoreg  output  1  writeback data select: 0 = ALUOut, 1 = data register
- regwrite  output  1  register file write enable
- alusrca  output  1  ALU A select: 0 = PC, 1 = A register
- alusrcb  output  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2
- pcsrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  output  3  ALU function: 010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal  output  1  one-cycle pulse in DECODE on an unsupported opcode

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010, bne 000101 (bne only with the macro enabled).
- States and next state:
  - FETCH → DECODE.
  - DECODE → MEMADR (lw/sw), EXECUTE (R), BEQ, ADDIEXEC, JUMP, BNE; any other opcode → FETCH.
  - MEMADR → MEMRD (lw) or MEMWR (sw). MEMRD → MEMWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BEQ, BNE and JUMP → FETCH.
  - EXECUTE → ALUWB. ADDIEXEC → ADDIWB.
- Output decode (every unlisted output is 0):
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00.
  - DECODE: alusrcb=11, aluop=00.
  - MEMADR and ADDIEXEC: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10.
  - ALUWB: regdst=1, regwrite=1.
  - ADDIWB: regwrite=1.
  - BEQ: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - BNE: alusrca=1, aluop=01, pcsrc=01, branchne=1.
  - JUMP: pcsrc=10, pcwrite=1.
- pcen = pcwrite | (branch & zero) | (branchne & ~zero).
- ALU decode:
  - aluop 00 → add; aluop 01 → sub.
  - aluop 10 → decode funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other funct → add (deterministic, never X).
- Instruction lengths in cycles: lw 5, sw 4, R 4, addi 4, beq 3, bne 3, j 3, illegal 2.

## Timing
- State register updates on the rising clk edge. Outputs are Moore-decoded from state, except:
  - pcen, which also depends combinationally on zero;
  - alucontrol, which also depends combinationally on funct.
- Reset: a rising edge with reset=0 loads FETCH.
- While reset=0, pcen, irwrite, regwrite, memwrite and illegal are forced to 0 combinationally, and all other outputs read 0.
- Reset deasserted mid-instruction: the state is FETCH on the next edge and no partial writeback occurs.
- illegal is high exactly during the DECODE cycle of an unsupported opcode. No datapath write occurs for that instruction beyond its FETCH.
- op and funct must be stable from the end of FETCH onward; they are valid because irwrite is high only in FETCH.

## Configuration
- MC_BNE_EN defined: BNE state exists; opcode 000101 takes 3 cycles and branches when zero=0.
- MC_BNE_EN undefined: no BNE state, branchne is tied 0, and opcode 000101 is illegal (illegal pulse, return to FETCH).

## Structure
- Package mc_ctrl_pkg holds:
  - the state enum statetype;
  - opcode localparams;
  - aluop codes;
  - alucontrol codes.
- One combinational sub-module, aludec (inputs funct and aluop, output alucontrol). The FSM and output decode live in mc_controller.

## Test plan
- Reset: hold reset=0 for 2 edges → pcen=irwrite=regwrite=memwrite=0. After release, the first cycle is FETCH with irwrite=1 and pcen=1.
- lw (op=100011): 5 cycles. MEMRD has iord=1; MEMWB has regwrite=1, memtoreg=1, regdst=0; then FETCH.
- sw, then R-type sub (funct=100010):
  - sw: memwrite=1 in cycle 4 only.
  - sub: EXECUTE shows alucontrol=110; ALUWB shows regdst=1 and regwrite=1.
- beq (000100):
  - zero=1 → pcen=1 in cycle 3, pcsrc=01.
  - zero=0 → pcen=0.
  - Next cycle is FETCH in both cases.
- j (000010): cycle 3 has pcsrc=10 and pcen=1.
  - op=111111 → illegal=1 in DECODE, then FETCH, with no regwrite or memwrite.
- Macro variant: op=000101 with zero=0.
  - MC_BNE_EN defined → pcen=1 in cycle 3.
  - MC_BNE_EN undefined → illegal pulse.
- Reset during MEMRD of lw → next state is FETCH and no regwrite occurs.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: FSM state
// encoding, opcodes, ALU-op codes and ALU function codes.
// Build option: MC_BNE_EN adds the BNE state and the bne opcode.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BEQ      = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
`ifdef MC_BNE_EN
        ,
        BNE      = 4'd12
`endif
    } statetype;

    // Opcodes, instruction[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    // aluop: how the ALU decoder chooses its function
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // alucontrol codes driven to the ALU
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // R-type funct field values
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps aluop (and funct for R-type) to the ALU function code.
// Purely combinational; unknown funct/aluop values resolve to add.
module aludec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [1:0] aluop,
    output logic [2:0] alucontrol
);

    // Select ALU function from aluop, falling through to funct for R-type
    always_comb begin
        // NOTE: default assigned first so every path drives the output and no latch is inferred.
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback and driving every datapath enable and mux select.
// While reset is low every output reads 0.
// Build option: MC_BNE_EN enables the bne instruction (BNE state).
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal
);

    statetype   state_q, state_d;

    logic       pcwrite, branch, branchne;
    logic       iord_s, memwrite_s, irwrite_s, regdst_s, memtoreg_s;
    logic       regwrite_s, alusrca_s, illegal_s;
    logic [1:0] alusrcb_s, pcsrc_s, aluop;
    logic [2:0] alucontrol_s;

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // Next-state logic and Moore output decode
    always_comb begin
        state_d    = state_q;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        branchne   = 1'b0;
        iord_s     = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        regdst_s   = 1'b0;
        memtoreg_s = 1'b0;
        regwrite_s = 1'b0;
        alusrca_s  = 1'b0;
        alusrcb_s  = 2'b00;
        pcsrc_s    = 2'b00;
        aluop      = ALUOP_ADD;
        illegal_s  = 1'b0;
        case (state_q)
            FETCH: begin
                irwrite_s = 1'b1;
                pcwrite   = 1'b1;
                alusrcb_s = 2'b01;
                state_d   = DECODE;
            end
            DECODE: begin
                alusrcb_s = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BEQ;
                    OP_ADDI:      state_d = ADDIEXEC;
                    OP_J:         state_d = JUMP;
`ifdef MC_BNE_EN
                    OP_BNE:       state_d = BNE;
`endif
                    default: begin
                        illegal_s = 1'b1;
                        state_d   = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                state_d   = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord_s  = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                memtoreg_s = 1'b1;
                regwrite_s = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                iord_s     = 1'b1;
                memwrite_s = 1'b1;
                state_d    = FETCH;
            end
            EXECUTE: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b00;
                aluop     = ALUOP_FUNCT;
                state_d   = ALUWB;
            end
            ALUWB: begin
                regdst_s   = 1'b1;
                regwrite_s = 1'b1;
                state_d    = FETCH;
            end
            ADDIEXEC: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                regwrite_s = 1'b1;
                state_d    = FETCH;
            end
            BEQ: begin
                alusrca_s = 1'b1;
                aluop     = ALUOP_SUB;
                pcsrc_s   = 2'b01;
                branch    = 1'b1;
                state_d   = FETCH;
            end
`ifdef MC_BNE_EN
            BNE: begin
                alusrca_s = 1'b1;
                aluop     = ALUOP_SUB;
                pcsrc_s   = 2'b01;
                branchne  = 1'b1;
                state_d   = FETCH;
            end
`endif
            JUMP: begin
                pcsrc_s = 2'b10;
                pcwrite = 1'b1;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    aludec u_aludec (
        .funct      (funct),
        .aluop      (aluop),
        .alucontrol (alucontrol_s)
    );

    // Every output is held at 0 while reset is asserted
    assign pcen       = reset & (pcwrite | (branch & zero) | (branchne & ~zero));
    assign iord       = reset & iord_s;
    assign memwrite   = reset & memwrite_s;
    assign irwrite    = reset & irwrite_s;
    assign regdst     = reset & regdst_s;
    assign memtoreg   = reset & memtoreg_s;
    assign regwrite   = reset & regwrite_s;
    assign alusrca    = reset & alusrca_s;
    assign alusrcb    = reset ? alusrcb_s    : 2'b00;
    assign pcsrc      = reset ? pcsrc_s      : 2'b00;
    assign alucontrol = reset ? alucontrol_s : 3'b000;
    assign illegal    = reset & illegal_s;

endmodule
